// File: rtl/fifo_plus.sv
// rtl/fifo_plus.sv - single-clock FIFO with occupancy/threshold flags and sticky errors
// Define FIFO_PLUS_FWFT_EN for first-word-fall-through read data; default is a registered read.
module fifo_plus #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 7,
  parameter int AF_LEVEL = 120,
  parameter int AE_LEVEL = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             insert,
  input  logic             remove,
  input  logic             flush,
  input  logic             clear_err,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [DEPTH:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [DEPTH:0] CAP  = (DEPTH+1)'(2**DEPTH);
  localparam logic [DEPTH:0] AF_L = (DEPTH+1)'(AF_LEVEL);
  localparam logic [DEPTH:0] AE_L = (DEPTH+1)'(AE_LEVEL);

  logic [WIDTH-1:0] mem [0:2**DEPTH-1];
  logic [DEPTH-1:0] wr_ptr;
  logic [DEPTH-1:0] rd_ptr;
  logic             wr_ok;
  logic             rd_ok;
  logic             ovf_set;
  logic             udf_set;

  // Flags decode only the registered count, so no input reaches them combinationally.
  assign full         = (count == CAP);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_L);
  assign almost_empty = (count <= AE_L);

  assign rd_ok   = remove & ~empty & ~flush;
  assign wr_ok   = insert & ~flush & (~full | remove);
  assign ovf_set = insert & full & ~remove & ~flush;
  assign udf_set = remove & empty & ~flush;

  always_ff @(posedge clk_in) begin
    if (wr_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + DEPTH'(1);
        if (rd_ok) rd_ptr <= rd_ptr + DEPTH'(1);
        if (wr_ok && !rd_ok)      count <= count + (DEPTH+1)'(1);
        else if (rd_ok && !wr_ok) count <= count - (DEPTH+1)'(1);
      end
      // A new error in the same cycle as clear_err keeps the flag set.
      if (ovf_set)        overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;
      if (udf_set)        underflow <= 1'b1;
      else if (clear_err) underflow <= 1'b0;
    end
  end

`ifdef FIFO_PLUS_FWFT_EN
  assign data_out = mem[rd_ptr];
`else
  // Full with simultaneous insert+remove reads the old word: the array write lands after this read.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset)      data_out <= '0;
    else if (rd_ok) data_out <= mem[rd_ptr];
  end
`endif

endmodule

// File: tb/tb_fifo_plus.sv
// tb/tb_fifo_plus.sv - scoreboard bench for fifo_plus (default parameters)
// Define FIFO_PLUS_FWFT_EN to check the first-word-fall-through build.
module tb_fifo_plus;

  localparam int CAP = 128;
  localparam int AFL = 120;
  localparam int AEL = 8;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        insert, remove, flush, clear_err;
  logic [31:0] data_out;
  logic        full, empty, almost_full, almost_empty;
  logic [7:0]  count;
  logic        overflow, underflow;

  fifo_plus dut (
    .clk_in(clk_in), .reset(reset), .data_in(data_in), .insert(insert),
    .remove(remove), .flush(flush), .clear_err(clear_err), .data_out(data_out),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk_in = ~clk_in;

  logic [31:0] sb[$];
  logic        movf, mudf;
  logic [31:0] mdout;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("count", 32'(count), 32'(sb.size()));
    chk("empty", 32'(empty), 32'(sb.size() == 0));
    chk("full", 32'(full), 32'(sb.size() == CAP));
    chk("almost_full", 32'(almost_full), 32'(sb.size() >= AFL));
    chk("almost_empty", 32'(almost_empty), 32'(sb.size() <= AEL));
    chk("overflow", 32'(overflow), 32'(movf));
    chk("underflow", 32'(underflow), 32'(mudf));
`ifdef FIFO_PLUS_FWFT_EN
    if (sb.size() > 0) chk("fwft_head", data_out, sb[0]);
`else
    chk("data_out", data_out, mdout);
`endif
  endtask

  // Drives one cycle at posedge+1, updates the model after the edge and checks everything.
  task automatic step(input logic ins, input logic rem, input logic [31:0] d,
                      input logic fl, input logic clr);
    logic w, r, oset, uset;
    logic [31:0] popped;
    insert = ins; remove = rem; data_in = d; flush = fl; clear_err = clr;
    r    = rem && sb.size() != 0 && !fl;
    w    = ins && !fl && (sb.size() != CAP || rem);
    oset = ins && sb.size() == CAP && !rem && !fl;
    uset = rem && sb.size() == 0 && !fl;
    @(posedge clk_in);
    #1;
    if (r) begin
      popped = sb.pop_front();
      mdout  = popped;
    end
    if (w) sb.push_back(d);
    if (fl) sb.delete();
    movf = oset ? 1'b1 : (clr ? 1'b0 : movf);
    mudf = uset ? 1'b1 : (clr ? 1'b0 : mudf);
    insert = 1'b0; remove = 1'b0; flush = 1'b0; clear_err = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    insert = 1'b0; remove = 1'b0; flush = 1'b0; clear_err = 1'b0;
    @(negedge clk_in);
    reset = 1'b1;
    #1;
    sb.delete(); movf = 1'b0; mudf = 1'b0; mdout = '0;
    check_all();
    @(negedge clk_in);
    reset = 1'b0;
    @(posedge clk_in);
    #1;
    check_all();
  endtask

  logic [31:0] pat [10] = '{32'hFFFFFFFF, 32'h00000000, 32'hA5A5A5A5, 32'h5A5A5A5A,
                            32'h12345678, 32'hDEADBEEF, 32'hCAFEBABE, 32'h0000FFFF,
                            32'hFFFF0000, 32'h87654321};

  initial begin
    reset = 1'b1; data_in = '0; insert = 1'b0; remove = 1'b0; flush = 1'b0; clear_err = 1'b0;
    movf = 1'b0; mudf = 1'b0; mdout = '0;
    repeat (2) @(posedge clk_in);
    #1;
    check_all();
    @(negedge clk_in);
    reset = 1'b0;
    @(posedge clk_in);
    #1;
    check_all();

    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, pat[i], 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b1, '0, 1'b0, 1'b0);

    for (int i = 0; i < 129; i++) step(1'b1, 1'b0, $urandom, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
    repeat (128) step(1'b0, 1'b1, '0, 1'b0, 1'b0);

    step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h11112222, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0, 1'b1);
    step(1'b0, 1'b1, '0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) step(1'b1, 1'b0, $urandom, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h0BADF00D, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    for (int i = 0; i < 128; i++) step(1'b1, 1'b0, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 128; i++) step(1'b0, 1'b1, '0, 1'b0, 1'b0);

    step(1'b1, 1'b0, 32'hABCDEFAB, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, $urandom, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 1'b0, 32'h13579BDF, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
